counter_controller: RTL
=======================

COUNTER_CONTROLLER -- requirements
Module: counter_controller

Interface
REQ-001 Parameter DIV, default 4: clk cycles per count tick; legal range 1..65535.
REQ-002 Parameter WRAP, default 1: 1 = roll 9999->0000 and keep running; 0 = halt at 9999.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level sampled each cycle; begins or resumes counting.
REQ-006 stop  input  1  level sampled each cycle; pauses counting.
REQ-007 clear  input  1  level sampled each cycle; returns block to IDLE with digits zeroed.
REQ-008 cnt0..cnt3  output  4 each  BCD digits, cnt0 least significant, registered.
REQ-009 en0..en3  output  1 each  one-cycle increment strobe per digit, registered, same cycle as the digit update.
REQ-010 running  output  1  high while state is RUN.
REQ-011 done  output  1  high while state is DONE.

Function
REQ-012 FSM SHALL have states IDLE, RUN, PAUSE, DONE.
REQ-013 Input priority SHALL be clear > stop > start.
REQ-014 IDLE: start -> RUN; prescaler starts at 0.
REQ-015 RUN: stop -> PAUSE; prescaler and digits hold their values.
REQ-016 PAUSE: start -> RUN; prescaler resumes from its held value, no restart.
REQ-017 DONE: only clear exits; start and stop are ignored.
REQ-018 clear in any state -> IDLE next cycle: digits 0, prescaler 0, no en strobe that cycle.
REQ-019 Prescaler (16 bit) SHALL count 0..DIV-1 only in RUN; a tick occurs in the cycle where it equals DIV-1, and it then returns to 0.
REQ-020 DIV=1 SHALL tick every RUN cycle.
REQ-021 On a tick: cnt0 increments and en0 pulses; digit k at 9 wraps to 0, and digit k+1 increments with en(k+1) pulsing in the same cycle (full ripple within one cycle).
REQ-022 Digits SHALL never hold values 10..15.
REQ-023 Tick at 9999 with WRAP=1: all digits -> 0, en0..en3 all pulse, state stays RUN.
REQ-024 Tick at 9999 with WRAP=0: digits hold 9999, no en strobes, state -> DONE.
REQ-025 A stop arriving in the same cycle as a tick SHALL apply the tick, then move to PAUSE.
REQ-026 A clear arriving in the same cycle as a tick: clear wins, tick discarded.
REQ-027 start while already in RUN SHALL have no effect; stop in IDLE SHALL have no effect.
REQ-028 Output latency: digits, en, running and done SHALL reflect the edge that changed state; there are no combinational input-to-output paths.

Reset
REQ-029 rst low SHALL immediately force: state IDLE, prescaler 0, cnt0..cnt3 = 0, en0..en3 = 0, running = 0, done = 0.
REQ-030 Reset asserted mid-count SHALL discard all progress; no strobe is emitted during reset.
REQ-031 After rst rises, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-032 Count: DIV=4, start pulse, 40 cycles -> cnt0..cnt3 = 0,1,0,0 (count 10); en1 pulses once, on the 10th tick.
REQ-033 Pause: DIV=4; stop after 2 prescaler cycles; hold 20 cycles; restart -> next tick after exactly 2 more cycles, digits unchanged while paused.
REQ-034 Wrap: WRAP=1, DIV=1, reach 9999, one more cycle -> 0000, en0..en3 all high for one cycle, running=1.
REQ-035 Halt: WRAP=0, DIV=1, reach 9999 -> done=1, running=0, digits stay 9999; start ignored; clear -> IDLE, 0000.
REQ-036 Collisions: clear coincident with tick -> 0000, no en; stop coincident with tick -> count applied, state PAUSE; start and stop together in IDLE -> stay IDLE.
REQ-037 Async reset: drop rst between clk edges while at 0357 -> outputs zero before the next edge; release and start -> counting restarts from 0000.

Source files
------------

// File: rtl/counter_controller.sv
// Four-digit BCD event counter with prescaled tick, run/pause/halt control.
// state | meaning
// IDLE  | digits zeroed, waiting for start
// RUN   | prescaler advancing, digits count on each tick
// PAUSE | prescaler and digits frozen, start resumes
// DONE  | halted at 9999 (WRAP=0), only clear exits
module counter_controller #(
    parameter int unsigned DIV  = 4,
    parameter bit          WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] cnt0,
    output logic [3:0] cnt1,
    output logic [3:0] cnt2,
    output logic [3:0] cnt3,
    output logic       en0,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

    state_t      state;
    logic [15:0] presc;
    logic        tick;
    logic [3:0]  inc;
    logic        all_nine;
    logic        halt;

    function automatic logic [3:0] bump(input logic [3:0] d, input logic i);
        if (!i)
            return d;
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Carry chain: digit k increments when every lower digit is rolling over from 9.
    assign tick     = (presc == PRESC_LAST);
    assign inc[0]   = 1'b1;
    assign inc[1]   = (cnt0 == 4'd9);
    assign inc[2]   = inc[1] && (cnt1 == 4'd9);
    assign inc[3]   = inc[2] && (cnt2 == 4'd9);
    assign all_nine = inc[3] && (cnt3 == 4'd9);
    assign halt     = tick && all_nine && (WRAP == 1'b0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            presc   <= '0;
            cnt0    <= '0;
            cnt1    <= '0;
            cnt2    <= '0;
            cnt3    <= '0;
            en0     <= 1'b0;
            en1     <= 1'b0;
            en2     <= 1'b0;
            en3     <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            en0 <= 1'b0;
            en1 <= 1'b0;
            en2 <= 1'b0;
            en3 <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                presc   <= '0;
                cnt0    <= '0;
                cnt1    <= '0;
                cnt2    <= '0;
                cnt3    <= '0;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        presc <= '0;
                        if (!stop && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        presc <= tick ? 16'd0 : presc + 16'd1;
                        if (halt) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            if (tick) begin
                                cnt0 <= bump(cnt0, inc[0]);
                                cnt1 <= bump(cnt1, inc[1]);
                                cnt2 <= bump(cnt2, inc[2]);
                                cnt3 <= bump(cnt3, inc[3]);
                                en0  <= inc[0];
                                en1  <= inc[1];
                                en2  <= inc[2];
                                en3  <= inc[3];
                            end
                            // A stop coincident with a tick still lets the tick land.
                            if (stop) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!stop && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
